// File: rtl/phase_shift_gen.sv
// Multi-channel phase-shifted square-wave generator: one shared period counter,
// per-channel signed delays loaded over valid/ready and applied at the period wrap.
module phase_shift_gen #(
  parameter int HALF_PERIOD = 625,
  parameter int CH          = 4,
  parameter int DW          = 12
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  en,
  input  logic                                  cfg_valid,
  output logic                                  cfg_ready,
  input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] cfg_ch,
  input  logic signed [DW-1:0]                  cfg_delay,
  output logic                                  cfg_err,
  output logic                                  sync_out,
  output logic [CH-1:0]                         clk_out
);

  localparam int P   = 2 * HALF_PERIOD;
  localparam int CW  = $clog2(P);
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

  localparam logic [CW-1:0]        LAST = CW'(P - 1);
  localparam logic [CW:0]          P_W  = (CW + 1)'(P);
  localparam logic [CW:0]          H_W  = (CW + 1)'(HALF_PERIOD);
  localparam logic [CHW:0]         CH_L = (CHW + 1)'(CH);
  localparam logic signed [DW:0]   P_S  = (DW + 1)'(P);

  logic [CW-1:0]            cnt;
  logic [CH-1:0][CW-1:0]    active_d;
  logic [CH-1:0][CW-1:0]    pend_d;
  logic [CH-1:0]            pend_flag;
  logic [CH-1:0][CW:0]      phase;

  logic                     wrap;
  logic                     ch_ok;
  logic                     in_range;
  logic                     accept;
  logic                     write_ok;
  logic signed [DW:0]       d_ext;
  logic [CW-1:0]            d_store;

  assign wrap     = en && (cnt == LAST);
  assign ch_ok    = ({1'b0, cfg_ch} < CH_L);
  assign d_ext    = {cfg_delay[DW-1], cfg_delay};
  assign in_range = (d_ext < P_S) && (d_ext > -P_S);
  assign accept   = cfg_valid && cfg_ready;
  assign write_ok = accept && ch_ok && in_range;

  // Negative delays fold into [0,P-1]; low-bit arithmetic is exact because d+P < 2^CW.
  assign d_store  = cfg_delay[DW-1] ? (cfg_delay[CW-1:0] + CW'(P)) : cfg_delay[CW-1:0];

  // NOTE: every always_comb output gets a default before any conditional write, so no latch is inferred.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < CH; i++) begin
      if (cfg_ch == CHW'(i)) cfg_ready = ~pend_flag[i];
    end
  end

  // (cnt - d) mod P, computed in CW+1 bits so the +P bias never overflows.
  always_comb begin
    phase = '0;
    for (int i = 0; i < CH; i++) begin
      phase[i] = {1'b0, cnt} + P_W - {1'b0, active_d[i]};
      if (phase[i] >= P_W) phase[i] = phase[i] - P_W;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      cfg_err   <= 1'b0;
      sync_out  <= 1'b0;
      clk_out   <= '0;
      pend_flag <= '0;
      // NOTE: the delay tables are reset because a restart must begin with zero offsets on every channel.
      active_d  <= '0;
      pend_d    <= '0;
    end else begin
      if (!en || wrap) cnt <= '0;
      else             cnt <= cnt + CW'(1);

      cfg_err  <= accept && !write_ok;
      sync_out <= en && (cnt == '0);

      for (int i = 0; i < CH; i++) begin
        clk_out[i] <= en && (phase[i] < H_W);
        // A set flag holds ready low, so a write and an apply never hit the same channel together.
        if (write_ok && (cfg_ch == CHW'(i))) begin
          pend_d[i]    <= d_store;
          pend_flag[i] <= 1'b1;
        end else if (pend_flag[i] && (wrap || !en)) begin
          active_d[i]  <= pend_d[i];
          pend_flag[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_phase_shift_gen.sv
// Directed bench for phase_shift_gen with P=8, CH=2, DW=5; a CH=3 copy covers the out-of-range channel.
module tb_phase_shift_gen;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [0:0] cfg_ch;
  logic signed [4:0] cfg_delay;
  logic       cfg_err;
  logic       sync_out;
  logic [1:0] clk_out;

  logic       cfg_valid3;
  logic       cfg_ready3;
  logic [1:0] cfg_ch3;
  logic       cfg_err3;
  logic       sync_out3;
  logic [2:0] clk_out3;

  int total = 0;
  int bad   = 0;

  // Expected output per period, MSB = phase 0 (pattern for delay d, P=8, half=4).
  localparam logic [7:0] PD0 = 8'b11110000;
  localparam logic [7:0] PD2 = 8'b00111100;
  localparam logic [7:0] PD3 = 8'b00011110;
  localparam logic [7:0] PD5 = 8'b10000111;
  localparam logic [7:0] PD6 = 8'b11000011;

  phase_shift_gen #(.HALF_PERIOD(4), .CH(2), .DW(5)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_delay (cfg_delay),
    .cfg_err   (cfg_err),
    .sync_out  (sync_out),
    .clk_out   (clk_out)
  );

  // With CH=2 the channel field is 1 bit wide, so channel 3 is only expressible on a CH=3 instance.
  phase_shift_gen #(.HALF_PERIOD(4), .CH(3), .DW(5)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_valid (cfg_valid3),
    .cfg_ready (cfg_ready3),
    .cfg_ch    (cfg_ch3),
    .cfg_delay (cfg_delay),
    .cfg_err   (cfg_err3),
    .sync_out  (sync_out3),
    .clk_out   (clk_out3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks phases lo..hi of the current period, one negedge per phase.
  task automatic check_span(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input int lo, input int hi);
    for (int j = lo; j <= hi; j++) begin
      check({tag, "_ch0"}, 32'(clk_out[0]), 32'(e0[7-j]));
      check({tag, "_ch1"}, 32'(clk_out[1]), 32'(e1[7-j]));
      check({tag, "_sync"}, 32'(sync_out), 32'(j == 0));
      @(negedge clk);
    end
  endtask

  task automatic cfg_write(input string tag, input logic ch, input logic signed [4:0] d,
                           input logic exp_err);
    cfg_ch    = ch;
    cfg_delay = d;
    cfg_valid = 1'b1;
    #1;
    check({tag, "_ready"}, 32'(cfg_ready), 32'd1);
    @(negedge clk);
    cfg_valid = 1'b0;
    check({tag, "_err"}, 32'(cfg_err), 32'(exp_err));
    @(negedge clk);
    check({tag, "_err_clr"}, 32'(cfg_err), 32'd0);
  endtask

  initial begin
    int n;
    rst_n      = 1'b0;
    en         = 1'b0;
    cfg_valid  = 1'b0;
    cfg_ch     = '0;
    cfg_delay  = '0;
    cfg_valid3 = 1'b0;
    cfg_ch3    = '0;

    // Reset state
    @(negedge clk);
    check("rst_clk_out", 32'(clk_out), 32'd0);
    check("rst_sync", 32'(sync_out), 32'd0);
    check("rst_err", 32'(cfg_err), 32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd1);

    // 1: free run with zero delays
    rst_n = 1'b1;
    en    = 1'b1;
    n = 0;
    @(negedge clk);
    while (!sync_out && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t1_sync_found", 32'(sync_out), 32'd1);
    check_span("t1a", PD0, PD0, 0, 7);
    check_span("t1b", PD0, PD0, 0, 7);

    // 2: ch1 delay 2 written mid-period, lands only after the wrap
    check_span("t2_pre", PD0, PD0, 0, 2);
    cfg_write("t2_wr", 1'b1, 5'sd2, 1'b0);
    check_span("t2_hold", PD0, PD0, 5, 7);
    check_span("t2a", PD0, PD2, 0, 7);
    check_span("t2b", PD0, PD2, 0, 7);

    // 3: ch1 delay -2 normalises to 6
    cfg_write("t3_wr", 1'b1, -5'sd2, 1'b0);
    check_span("t3_hold", PD0, PD2, 2, 7);
    check_span("t3", PD0, PD6, 0, 7);

    // 4: out-of-range delays and channel are flagged and discarded
    cfg_write("t4_pos8", 1'b0, 5'sd8, 1'b1);
    cfg_write("t4_neg8", 1'b0, -5'sd8, 1'b1);
    cfg_ch3    = 2'd3;
    cfg_valid3 = 1'b1;
    #1;
    check("t4_ch3_ready", 32'(cfg_ready3), 32'd1);
    @(negedge clk);
    cfg_valid3 = 1'b0;
    check("t4_ch3_err", 32'(cfg_err3), 32'd1);
    @(negedge clk);
    check("t4_ch3_err_clr", 32'(cfg_err3), 32'd0);
    check_span("t4_hold", PD0, PD6, 6, 7);
    check_span("t4", PD0, PD6, 0, 7);

    // 5: back-to-back writes to ch0; the second waits for the wrap
    cfg_write("t5_wr3", 1'b0, 5'sd3, 1'b0);
    cfg_ch    = 1'b0;
    cfg_delay = 5'sd5;
    cfg_valid = 1'b1;
    #1;
    for (int j = 2; j <= 7; j++) begin
      check("t5_ready", 32'(cfg_ready), 32'(j == 7));
      check("t5_old_ch0", 32'(clk_out[0]), 32'(PD0[7-j]));
      check("t5_old_ch1", 32'(clk_out[1]), 32'(PD6[7-j]));
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    check("t5_err", 32'(cfg_err), 32'd0);
    check_span("t5_d3", PD3, PD6, 0, 7);
    check_span("t5_d5", PD5, PD6, 0, 7);

    // 6: async reset while ch0 is high
    check("t6_pre_high", 32'(clk_out[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_clk_out", 32'(clk_out), 32'd0);
    @(negedge clk);
    check("t6_rst_sync", 32'(sync_out), 32'd0);
    check("t6_rst_ready", 32'(cfg_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check_span("t6_restart", PD0, PD0, 0, 7);

    // 6: en low for 10 cycles; a write made meanwhile applies at once
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t6_en_low_clk_out", 32'(clk_out), 32'd0);
      check("t6_en_low_sync", 32'(sync_out), 32'd0);
      if (i == 1) begin
        cfg_ch    = 1'b1;
        cfg_delay = 5'sd2;
        cfg_valid = 1'b1;
        #1;
        check("t6_en_low_ready", 32'(cfg_ready), 32'd1);
      end
      if (i == 2) begin
        check("t6_en_low_pending", 32'(cfg_ready), 32'd0);
        cfg_valid = 1'b0;
      end
      if (i == 3) check("t6_en_low_applied", 32'(cfg_ready), 32'd1);
    end
    en = 1'b1;
    @(negedge clk);
    check_span("t6_en_rise", PD0, PD2, 0, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
